matrix_tile_loader: RTL and testbench

Downstream of the AXI-Stream command receiver. Turns its load pulse, dimensions and per-byte payload into row-major write transactions for the A and B matrix tile memories. After the payload it zero-pads the unused part of the MMU_SIZE×MMU_SIZE tile, so the MMU always reads clean tiles. It throttles the receiver through `ready` while padding.

---
 rtl/matrix_tile_loader.sv | 168 ++++++++++++++++
 tb/tb_matrix_tile_loader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_tile_loader.sv
// Tile loader: payload bytes -> row-major tile writes, zero-pads the remainder.
// Ports: load/fields/data_valid/data_in in; ready/busy/done/err, wr_a_en/wr_b_en/wr_addr/wr_data out.
module matrix_tile_loader #(
  parameter int MMU_SIZE   = 10,
  parameter int BUFFER_CNT = 4,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              buffer_a_b,
  input  logic [4:0]        buffer_idx,
  input  logic [7:0]        dim_x,
  input  logic [7:0]        dim_y,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic              ready,
  output logic              wr_a_en,
  output logic              wr_b_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TILE = MMU_SIZE * MMU_SIZE;

  typedef enum logic [1:0] {
    IDLE, LOAD, PAD, DONE
  } state_t;

  state_t            state;
  logic              sel_b;
  logic [7:0]        dim_x_q;
  logic [7:0]        dim_y_q;
  logic [7:0]        r;
  logic [7:0]        c;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] pos;

  logic              load_ok;
  logic              dv;
  logic              row_end_ld;
  logic              last_ld;
  logic              row_end_pd;
  logic              last_pd;
  logic              hole;
  logic              full;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W-1:0] row_skip;

  assign load_ok = (dim_x <= 8'(MMU_SIZE))
                && (dim_y <= 8'(MMU_SIZE))
                && (buffer_idx < 5'(BUFFER_CNT));

  // data alongside a load is always dropped
  assign dv = data_valid && !load;

  // base computed once at load time, off the write path
  assign load_base = ADDR_W'(buffer_idx) * ADDR_W'(TILE);

  // jump from (r, dim_x-1) to (r+1, 0)
  assign row_skip = ADDR_W'(MMU_SIZE) - ADDR_W'(dim_x_q)
                  + ADDR_W'(1);

  assign row_end_ld = (c == dim_x_q - 8'd1);
  assign last_ld    = row_end_ld
                   && (r == dim_y_q - 8'd1);
  assign row_end_pd = (c == 8'(MMU_SIZE - 1));
  assign last_pd    = row_end_pd
                   && (r == 8'(MMU_SIZE - 1));
  assign hole       = (r >= dim_y_q) || (c >= dim_x_q);
  assign full       = (dim_x_q == 8'(MMU_SIZE))
                   && (dim_y_q == 8'(MMU_SIZE));

  assign ready = (state != PAD);
  assign busy  = (state == LOAD) || (state == PAD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_b   <= 1'b0;
      dim_x_q <= '0;
      dim_y_q <= '0;
      r       <= '0;
      c       <= '0;
      base    <= '0;
      pos     <= '0;
      wr_a_en <= 1'b0;
      wr_b_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      wr_a_en <= 1'b0;
      wr_b_en <= 1'b0;
      done    <= 1'b0;
      err     <= (load && !load_ok)
              || (data_valid && load)
              || (data_valid && (state == IDLE))
              || (data_valid && (state == DONE));
      if (load && load_ok) begin
        sel_b   <= buffer_a_b;
        dim_x_q <= dim_x;
        dim_y_q <= dim_y;
        r       <= '0;
        c       <= '0;
        base    <= load_base;
        pos     <= load_base;
        if (dim_x == 8'd0 || dim_y == 8'd0)
          state <= PAD;
        else
          state <= LOAD;
      end else begin
        unique case (state)
          IDLE: ;
          DONE: state <= IDLE;
          LOAD: begin
            if (dv) begin
              wr_a_en <= !sel_b;
              wr_b_en <= sel_b;
              wr_addr <= pos;
              wr_data <= data_in;
              if (last_ld) begin
                r   <= '0;
                c   <= '0;
                pos <= base;
                if (full) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state <= PAD;
                end
              end else if (row_end_ld) begin
                c   <= '0;
                r   <= r + 8'd1;
                pos <= pos + row_skip;
              end else begin
                c   <= c + 8'd1;
                pos <= pos + ADDR_W'(1);
              end
            end
          end
          PAD: begin
            wr_a_en <= hole && !sel_b;
            wr_b_en <= hole && sel_b;
            wr_addr <= pos;
            wr_data <= '0;
            pos     <= pos + ADDR_W'(1);
            if (last_pd) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (row_end_pd) begin
              c <= '0;
              r <= r + 8'd1;
            end else begin
              c <= c + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_tile_loader.sv
// Directed bench for matrix_tile_loader.
// Per-scenario tasks with inline checks and a summary line.
module tb_matrix_tile_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic       buffer_a_b;
  logic [4:0] buffer_idx;
  logic [7:0] dim_x;
  logic [7:0] dim_y;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;
  logic       wr_a_en;
  logic       wr_b_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rdy_lo = 0;
  int both_cnt = 0;
  int done_cyc = 0;
  int last_cyc = 0;

  logic [8:0] qa_addr[$];
  logic [7:0] qa_data[$];
  logic [8:0] qb_addr[$];
  logic [7:0] qb_data[$];
  logic [8:0] ex_addr[$];
  logic [7:0] ex_data[$];

  matrix_tile_loader #(
    .MMU_SIZE(10),
    .BUFFER_CNT(4),
    .ADDR_W(9)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .buffer_a_b(buffer_a_b),
    .buffer_idx(buffer_idx),
    .dim_x(dim_x),
    .dim_y(dim_y),
    .data_in(data_in),
    .data_valid(data_valid),
    .ready(ready),
    .wr_a_en(wr_a_en),
    .wr_b_en(wr_b_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_a_en) begin
      qa_addr.push_back(wr_addr);
      qa_data.push_back(wr_data);
    end
    if (wr_b_en) begin
      qb_addr.push_back(wr_addr);
      qb_data.push_back(wr_data);
    end
    if (wr_a_en && wr_b_en) both_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) err_cnt++;
    if (!ready) rdy_lo++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    qa_addr.delete();
    qa_data.delete();
    qb_addr.delete();
    qb_data.delete();
    ex_addr.delete();
    ex_data.delete();
    done_cnt = 0;
    err_cnt  = 0;
    rdy_lo   = 0;
    both_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic do_load(input logic ab, input int idx,
                         input int dx, input int dy,
                         input logic dv, input int dat);
    load       = 1'b1;
    buffer_a_b = ab;
    buffer_idx = 5'(idx);
    dim_x      = 8'(dx);
    dim_y      = 8'(dy);
    data_valid = dv;
    data_in    = 8'(dat);
    tick();
    load       = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic send_bytes(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      data_in    = 8'(first + i);
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    last_cyc   = cyc;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) tick();
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout got=none want=pulse");
    end
    repeat (3) tick();
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL done_pulses got=%0d want=1", done_cnt);
    end
  endtask

  // expected zero writes in tile t for cells outside dx x dy
  task automatic exp_pad(input int t, input int dx, input int dy);
    for (int rr = 0; rr < 10; rr++)
      for (int cc = 0; cc < 10; cc++)
        if (rr >= dy || cc >= dx) begin
          ex_addr.push_back(9'(t * 100 + rr * 10 + cc));
          ex_data.push_back(8'd0);
        end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({ready, busy, wr_a_en, wr_b_en, done, err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_outs got=%b want=100000",
               {ready, busy, wr_a_en, wr_b_en, done, err});
    end
    checks++;
    if (wr_addr !== 9'd0 || wr_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_bus got=%0d/%0d want=0/0", wr_addr, wr_data);
    end
    rst_n = 1'b1;
    tick();
    clear();
  endtask

  task automatic test_partial;
    int bad;
    clear();
    do_load(1'b0, 1, 3, 2, 1'b0, 0);
    send_bytes(11, 6);
    wait_done(300);
    for (int rr = 0; rr < 2; rr++)
      for (int cc = 0; cc < 3; cc++) begin
        ex_addr.push_back(9'(100 + rr * 10 + cc));
        ex_data.push_back(8'(11 + rr * 3 + cc));
      end
    exp_pad(1, 3, 2);
    checks++;
    if (qa_addr.size() !== 100) begin
      failures++;
      $display("FAIL partial_count got=%0d want=100", qa_addr.size());
    end
    bad = 0;
    for (int i = 0; i < 100 && i < qa_addr.size(); i++)
      if (qa_addr[i] !== ex_addr[i] || qa_data[i] !== ex_data[i]) begin
        if (bad == 0)
          $display("FAIL partial_seq idx=%0d got=%0d:%0d want=%0d:%0d",
                   i, qa_addr[i], qa_data[i], ex_addr[i], ex_data[i]);
        bad++;
      end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL partial_bad got=%0d want=0", bad);
    end
    checks++;
    if (rdy_lo !== 100) begin
      failures++;
      $display("FAIL partial_ready_low got=%0d want=100", rdy_lo);
    end
    checks++;
    if (done_cyc - last_cyc !== 100) begin
      failures++;
      $display("FAIL partial_done_lat got=%0d want=100",
               done_cyc - last_cyc);
    end
    checks++;
    if (qb_addr.size() !== 0) begin
      failures++;
      $display("FAIL partial_b_writes got=%0d want=0", qb_addr.size());
    end
  endtask

  task automatic test_full;
    int bad;
    clear();
    do_load(1'b1, 3, 10, 10, 1'b0, 0);
    send_bytes(0, 100);
    wait_done(20);
    checks++;
    if (qb_addr.size() !== 100) begin
      failures++;
      $display("FAIL full_count got=%0d want=100", qb_addr.size());
    end
    bad = 0;
    for (int i = 0; i < 100 && i < qb_addr.size(); i++)
      if (qb_addr[i] !== 9'(300 + i) || qb_data[i] !== 8'(i)) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL full_seq got=%0d bad want=0", bad);
    end
    checks++;
    if (done_cyc !== last_cyc) begin
      failures++;
      $display("FAIL full_done_lat got=%0d want=0", done_cyc - last_cyc);
    end
    checks++;
    if (rdy_lo !== 0 || qa_addr.size() !== 0) begin
      failures++;
      $display("FAIL full_ready_or_a got=%0d/%0d want=0/0",
               rdy_lo, qa_addr.size());
    end
  endtask

  task automatic test_zero_dim;
    int bad;
    clear();
    do_load(1'b0, 0, 0, 5, 1'b0, 0);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_pad_state got=%b%b want=01", ready, busy);
    end
    data_in = 8'h55;
    data_valid = 1'b1;
    repeat (5) tick();
    data_valid = 1'b0;
    wait_done(200);
    checks++;
    if (qa_addr.size() !== 100) begin
      failures++;
      $display("FAIL zero_count got=%0d want=100", qa_addr.size());
    end
    bad = 0;
    for (int i = 0; i < 100 && i < qa_addr.size(); i++)
      if (qa_addr[i] !== 9'(i) || qa_data[i] !== 8'd0) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL zero_seq got=%0d bad want=0", bad);
    end
    checks++;
    if (err_cnt !== 0 || rdy_lo !== 100) begin
      failures++;
      $display("FAIL zero_err_ready got=%0d/%0d want=0/100",
               err_cnt, rdy_lo);
    end
  endtask

  task automatic test_reject;
    clear();
    do_load(1'b0, 0, 4, 11, 1'b0, 0);
    tick();
    do_load(1'b1, 4, 2, 2, 1'b0, 0);
    repeat (4) tick();
    checks++;
    if (err_cnt !== 2) begin
      failures++;
      $display("FAIL reject_err got=%0d want=2", err_cnt);
    end
    checks++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reject_state got=%b%b want=01", busy, ready);
    end
    checks++;
    if (qa_addr.size() + qb_addr.size() !== 0 || done_cnt !== 0) begin
      failures++;
      $display("FAIL reject_writes got=%0d want=0",
               qa_addr.size() + qb_addr.size());
    end
  endtask

  task automatic test_restart;
    int bad;
    logic [8:0] a_exp[5];
    clear();
    a_exp = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd10};
    do_load(1'b0, 0, 4, 4, 1'b0, 0);
    send_bytes(1, 5);
    do_load(1'b1, 2, 2, 2, 1'b1, 8'h77);
    send_bytes(21, 4);
    wait_done(300);
    bad = 0;
    for (int i = 0; i < 5 && i < qa_addr.size(); i++)
      if (qa_addr[i] !== a_exp[i] || qa_data[i] !== 8'(1 + i)) bad++;
    checks++;
    if (qa_addr.size() !== 5 || bad !== 0) begin
      failures++;
      $display("FAIL restart_a got=%0d/%0d want=5/0",
               qa_addr.size(), bad);
    end
    for (int rr = 0; rr < 2; rr++)
      for (int cc = 0; cc < 2; cc++) begin
        ex_addr.push_back(9'(200 + rr * 10 + cc));
        ex_data.push_back(8'(21 + rr * 2 + cc));
      end
    exp_pad(2, 2, 2);
    checks++;
    if (qb_addr.size() !== 100) begin
      failures++;
      $display("FAIL restart_b_count got=%0d want=100", qb_addr.size());
    end
    bad = 0;
    for (int i = 0; i < 100 && i < qb_addr.size(); i++)
      if (qb_addr[i] !== ex_addr[i] || qb_data[i] !== ex_data[i]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL restart_b_seq got=%0d bad want=0", bad);
    end
    checks++;
    if (err_cnt !== 1) begin
      failures++;
      $display("FAIL restart_stray_err got=%0d want=1", err_cnt);
    end
  endtask

  task automatic test_reset_mid_pad;
    clear();
    do_load(1'b0, 1, 2, 2, 1'b0, 0);
    send_bytes(1, 4);
    repeat (10) tick();
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL midpad_in_pad got=%b want=0", ready);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({wr_a_en, wr_b_en, ready, busy, done} !== 5'b00100) begin
      failures++;
      $display("FAIL midpad_reset got=%b want=00100",
               {wr_a_en, wr_b_en, ready, busy, done});
    end
    clear();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (120) tick();
    checks++;
    if (qa_addr.size() + qb_addr.size() !== 0 || done_cnt !== 0) begin
      failures++;
      $display("FAIL midpad_after got=%0d/%0d want=0/0",
               qa_addr.size() + qb_addr.size(), done_cnt);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    buffer_a_b = 1'b0;
    buffer_idx = '0;
    dim_x      = '0;
    dim_y      = '0;
    data_in    = '0;
    data_valid = 1'b0;
    test_reset();
    test_partial();
    test_full();
    test_zero_dim();
    test_reject();
    test_restart();
    test_reset_mid_pad();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL both_strobes got=%0d want=0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
